note_duration_sequencer: RTL and testbench
==========================================

// Module: note_duration_sequencer
// PURPOSE
//  Consumes the 1-cycle 1/32-s tick from the beat generator. Plays a stream of {note, duration} entries
//  from the upstream song reader: holds each note on note_out for 'duration' beat ticks, then advances.
//  A one-entry pending register lets the next note load on the same edge the current one ends (no gap).
//  note_out feeds the tone/frequency stage downstream. Pulses note_done once per finished note.
// PARAMETERS
//  NOTE_W   6   width of note code; code 0 = rest/silence
//  DUR_W    6   width of duration field, in beat ticks (1/32 s units)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  beat       in   1       1-cycle tick from beat generator; ignored when not playing
//  in_valid   in   1       upstream entry valid
//  in_note    in   NOTE_W  note code of offered entry
//  in_dur     in   DUR_W   duration of offered entry, in beats
//  in_ready   out  1       = !pend_valid && !reset; transfer when in_valid && in_ready
//  note_out   out  NOTE_W  note currently playing; 0 when idle
//  playing    out  1       a note is active
//  note_done  out  1       registered 1-cycle pulse, cycle after a note's final beat
//  pause      in   1       only when NOTE_SEQ_PAUSE_EN defined (see CONFIGURATION)
// BEHAVIOUR
//  - State: IDLE (playing=0) / PLAY (playing=1). Regs: cur_note, remain[DUR_W], pend_valid/note/dur.
//  - Reset: playing=0, note_out=0, remain=0, note_done=0, pend_valid=0. in_ready=0 during reset, 1 after.
//    Reset mid-note aborts it; no note_done.
//  - Accept at edge T: pend_* loaded, pend_valid=1 from T+1. in_valid with in_dur==0 is accepted and
//    discarded: pend_valid stays 0, no note, no note_done.
//  - IDLE with pend_valid: next edge moves pend to cur: playing=1, note_out=pend_note, remain=pend_dur,
//    pend_valid=0. Accept->note_out latency = 2 cycles.
//  - PLAY with beat=1 and remain>1: remain-=1.
//  - Final beat (PLAY, beat=1, remain==1): note_done=1 next cycle. Same edge:
//    - pend_valid=1: load pend into cur (playing stays 1, gapless), pend_valid=0.
//    - else: go to IDLE, note_out=0.
//  - A beat on the load edge is not counted. Note lasts exactly in_dur beat ticks after load:
//    (in_dur-1, in_dur] x 1/32 s.
//  - Accept and pend->cur move on the same edge: pend keeps the old entry; new one is not accepted
//    because in_ready=0 that cycle. No lost or duplicated entries.
//  - No wrap: remain only decrements from >=1 and reloads on load; max duration 2^DUR_W-1 beats.
//  - beat in IDLE: no effect. in_* ignored when in_ready=0.
// CONFIGURATION
//  NOTE_SEQ_PAUSE_EN defined:
//    - pause port exists; while pause=1, beats are ignored (remain frozen, note_out held).
//    - Loading and accept still operate. A final beat coinciding with pause=1 does not end the note.
//  NOTE_SEQ_PAUSE_EN undefined: no pause port; every beat in PLAY counts.
// TESTING
//  1 Reset: assert reset 2 cycles, beats toggling -> note_out=0, playing=0, note_done=0, in_ready=0
//    during reset, 1 after.
//  2 Single note: offer {note=5,dur=3}, beat every 4 cycles -> note_out=5 two cycles after accept;
//    note_done pulses once, cycle after 3rd beat; then note_out=0, playing=0.
//  3 Back-to-back: offer {7,2} then {9,1} immediately -> note_out 7 then 9 with no idle cycle;
//    two note_done pulses; in_ready low only while pend full.
//  4 Zero duration: offer {4,0} then {6,1} -> 4 never appears; 6 plays one beat; exactly one note_done.
//  5 Coincidence: beat on load edge of {3,1} -> not counted, note ends on next beat.
//    Reset during PLAY -> immediate IDLE, no note_done.
//  6 (NOTE_SEQ_PAUSE_EN) {2,2}, pause=1 across 3 beats then 0 -> note holds;
//    ends on 2nd unpaused beat with one note_done.

Source files
------------

// File: rtl/note_duration_sequencer.sv
// Note/duration sequencer: plays {note, duration} entries for a number of beat ticks, with a
// one-entry pending slot for gapless note changes. Optional pause input under NOTE_SEQ_PAUSE_EN.
module note_duration_sequencer #(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              beat,
`ifdef NOTE_SEQ_PAUSE_EN
   input  logic              pause,
`endif
   input  logic              in_valid,
   input  logic [NOTE_W-1:0] in_note,
   input  logic [DUR_W-1:0]  in_dur,
   output logic              in_ready,
   output logic [NOTE_W-1:0] note_out,
   output logic              playing,
   output logic              note_done
);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t            state_q, state_d;
   logic [NOTE_W-1:0] cur_note_q, cur_note_d;
   logic [DUR_W-1:0]  remain_q, remain_d;
   logic              pend_valid_q, pend_valid_d;
   logic [NOTE_W-1:0] pend_note_q, pend_note_d;
   logic [DUR_W-1:0]  pend_dur_q, pend_dur_d;
   logic              note_done_q, note_done_d;

   logic beat_eff;
   logic accept;
   logic final_beat;
   logic load;

`ifdef NOTE_SEQ_PAUSE_EN
   assign beat_eff = beat && !pause;
`else
   assign beat_eff = beat;
`endif

   assign in_ready   = !pend_valid_q && !reset;
   assign accept     = in_valid && in_ready;
   assign final_beat = (state_q == PLAY) && beat_eff && (remain_q <= DUR_W'(1));
   // Pending entry moves into the player whenever the player is free at the next edge.
   assign load       = pend_valid_q && ((state_q == IDLE) || final_beat);

   always_comb begin
      state_d      = state_q;
      cur_note_d   = cur_note_q;
      remain_d     = remain_q;
      pend_valid_d = pend_valid_q;
      pend_note_d  = pend_note_q;
      pend_dur_d   = pend_dur_q;
      note_done_d  = 1'b0;

      if (state_q == PLAY && beat_eff) begin
         if (final_beat) begin
            note_done_d = 1'b1;
            state_d     = IDLE;
            cur_note_d  = '0;
            remain_d    = '0;
         end else begin
            remain_d = remain_q - DUR_W'(1);
         end
      end

      if (load) begin
         state_d      = PLAY;
         cur_note_d   = pend_note_q;
         remain_d     = pend_dur_q;
         pend_valid_d = 1'b0;
      end

      // Zero-length entries are consumed but never reach the player.
      if (accept && (in_dur != '0)) begin
         pend_valid_d = 1'b1;
         pend_note_d  = in_note;
         pend_dur_d   = in_dur;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cur_note_q   <= '0;
         remain_q     <= '0;
         pend_valid_q <= 1'b0;
         pend_note_q  <= '0;
         pend_dur_q   <= '0;
         note_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_note_q   <= cur_note_d;
         remain_q     <= remain_d;
         pend_valid_q <= pend_valid_d;
         pend_note_q  <= pend_note_d;
         pend_dur_q   <= pend_dur_d;
         note_done_q  <= note_done_d;
      end
   end

   assign note_out  = cur_note_q;
   assign playing   = (state_q == PLAY);
   assign note_done = note_done_q;

endmodule

// File: tb/tb_note_duration_sequencer.sv
// Bench for note_duration_sequencer: vector table, hand sequences and random stimulus checked
// against an entry-queue model. Build with NOTE_SEQ_PAUSE_EN defined to exercise pause.
module tb_note_duration_sequencer;

`ifdef NOTE_SEQ_PAUSE_EN
   localparam bit PAUSE_EN = 1'b1;
`else
   localparam bit PAUSE_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       beat = 1'b0;
   logic       pause = 1'b0;
   logic       inValid = 1'b0;
   logic [5:0] inNote = '0;
   logic [5:0] inDur = '0;
   logic       inReady;
   logic [5:0] noteOut;
   logic       playing;
   logic       noteDone;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   note_duration_sequencer #(.NOTE_W(6), .DUR_W(6)) dut (
      .clk(clk),
      .reset(reset),
      .beat(beat),
`ifdef NOTE_SEQ_PAUSE_EN
      .pause(pause),
`endif
      .in_valid(inValid),
      .in_note(inNote),
      .in_dur(inDur),
      .in_ready(inReady),
      .note_out(noteOut),
      .playing(playing),
      .note_done(noteDone)
   );

   // Reference: a queue of waiting entries and a count of beats left for the sounding note.
   typedef struct {
      int note;
      int dur;
   } entry_t;

   entry_t mPend[$];
   int     mNote = 0;
   int     mLeft = 0;
   bit     mPlaying = 0;
   bit     mDone = 0;

   always @(posedge clk) begin
      bit     accepted;
      bit     counts;
      entry_t e;
      accepted = inValid && !reset && (mPend.size() == 0);
      if (reset) begin
         mPend.delete();
         mNote = 0;
         mLeft = 0;
         mPlaying = 0;
         mDone = 0;
      end else begin
         mDone = 0;
         counts = beat && !(PAUSE_EN && pause);
         if (mPlaying && counts) begin
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
               mDone = 1;
               mPlaying = 0;
               mNote = 0;
            end
         end
         if (!mPlaying && mPend.size() > 0) begin
            e = mPend.pop_front();
            mNote = e.note;
            mLeft = e.dur;
            mPlaying = 1;
         end
         if (accepted && inDur != 0) begin
            e.note = int'(inNote);
            e.dur = int'(inDur);
            mPend.push_back(e);
         end
      end
   end

   task automatic checkVal(input string name, input int act, input int exp);
      assertCount++;
      if (act != exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, "_note_out"}, int'(noteOut), mNote);
      checkVal({tag, "_playing"}, int'(playing), int'(mPlaying));
      checkVal({tag, "_note_done"}, int'(noteDone), int'(mDone));
      checkVal({tag, "_in_ready"}, int'(inReady), int'(!reset && mPend.size() == 0));
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare with the model.
   task automatic applyStimulus(input logic r, input logic b, input logic v,
                                input logic [5:0] n, input logic [5:0] d,
                                input logic p, input string tag);
      reset = r;
      beat = b;
      inValid = v;
      inNote = n;
      inDur = d;
      pause = p;
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   typedef struct {
      logic       b;
      logic       v;
      logic [5:0] n;
      logic [5:0] d;
      int         eNote;
      logic       eP;
      logic       eD;
      logic       eR;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int latency;
      int doneCount;
      int doneIdx;

      vecs[0]  = '{1'b0, 1'b1, 6'd7, 6'd2, 0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 6'd9, 6'd1, 7, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 6'd9, 6'd1, 7, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 6'd0, 6'd0, 7, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 6'd0, 6'd0, 9, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 6'd0, 6'd0, 9, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 6'd0, 6'd0, 0, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 6'd0, 6'd0, 0, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 6'd4, 6'd0, 0, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 6'd6, 6'd1, 0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 6'd0, 6'd0, 6, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 6'd0, 6'd0, 0, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 6'd0, 6'd0, 0, 1'b0, 1'b0, 1'b1};

      // Reset held two cycles with beats toggling.
      applyStimulus(1, 1, 1, 6'd5, 6'd3, 0, "rst0");
      applyStimulus(1, 0, 1, 6'd5, 6'd3, 0, "rst1");
      checkVal("rst_in_ready_low", int'(inReady), 0);
      checkVal("rst_note_out", int'(noteOut), 0);
      applyStimulus(0, 1, 0, 6'd0, 6'd0, 0, "rst_rel");
      checkVal("rst_in_ready_high", int'(inReady), 1);
      checkVal("rst_playing", int'(playing), 0);

      // Single note {5,3}, beat every fourth cycle.
      applyStimulus(0, 0, 1, 6'd5, 6'd3, 0, "single_acc");
      latency = -1;
      doneCount = 0;
      doneIdx = -1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, (i % 4 == 3), 0, 6'd0, 6'd0, 0, "single");
         if (latency < 0 && noteOut == 6'd5) latency = i + 2;
         if (noteDone) begin
            doneCount++;
            doneIdx = i;
         end
      end
      checkVal("single_latency", latency, 2);
      checkVal("single_done_count", doneCount, 1);
      checkVal("single_done_pos", doneIdx, 11);
      checkVal("single_end_note", int'(noteOut), 0);

      // Back-to-back, zero duration and load-edge beat vectors.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(0, vecs[i].b, vecs[i].v, vecs[i].n, vecs[i].d, 0, $sformatf("vec%0d", i));
         checkVal($sformatf("vec%0d_note", i), int'(noteOut), vecs[i].eNote);
         checkVal($sformatf("vec%0d_play", i), int'(playing), int'(vecs[i].eP));
         checkVal($sformatf("vec%0d_done", i), int'(noteDone), int'(vecs[i].eD));
         checkVal($sformatf("vec%0d_ready", i), int'(inReady), int'(vecs[i].eR));
      end

      // Reset in the middle of a note aborts it without note_done.
      applyStimulus(0, 0, 1, 6'd3, 6'd5, 0, "abort_acc");
      applyStimulus(0, 0, 0, 6'd0, 6'd0, 0, "abort_load");
      applyStimulus(0, 1, 0, 6'd0, 6'd0, 0, "abort_beat");
      checkVal("abort_playing_before", int'(playing), 1);
      applyStimulus(1, 1, 0, 6'd0, 6'd0, 0, "abort_rst");
      checkVal("abort_playing", int'(playing), 0);
      checkVal("abort_note", int'(noteOut), 0);
      applyStimulus(0, 1, 0, 6'd0, 6'd0, 0, "abort_after");
      checkVal("abort_no_done", int'(noteDone), 0);

      // Paused beats must not advance the note.
      if (PAUSE_EN) begin
         doneCount = 0;
         applyStimulus(0, 0, 1, 6'd2, 6'd2, 0, "pause_acc");
         applyStimulus(0, 0, 0, 6'd0, 6'd0, 0, "pause_load");
         for (int i = 0; i < 6; i++) begin
            applyStimulus(0, (i % 2 == 0), 0, 6'd0, 6'd0, 1, "pause_hold");
            if (noteDone) doneCount++;
         end
         checkVal("pause_note_held", int'(noteOut), 2);
         for (int i = 0; i < 4; i++) begin
            applyStimulus(0, (i % 2 == 0), 0, 6'd0, 6'd0, 0, "pause_run");
            if (noteDone) doneCount++;
         end
         checkVal("pause_done_count", doneCount, 1);
         checkVal("pause_end_note", int'(noteOut), 0);
      end

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] d;
         d = ($urandom_range(0, 49) == 0) ? 6'd63 : 6'($urandom_range(0, 5));
         applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 1) == 1), 6'($urandom_range(0, 63)), d,
                       ($urandom_range(0, 4) == 0), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
